display_timings_multi: RTL and testbench

//  Runtime-selectable video timing generator. It replaces the single-mode, parameter-fixed timing block.

---
 rtl/display_timings_multi.sv | 167 ++++++++++++++++
 tb/tb_display_timings_multi.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/display_timings_multi.sv
`default_nettype none
// display_timings_multi: four-mode CEA/VESA video timing generator with signed coordinates.
// The active mode changes only on the frame-wrap cycle; active sizes are overridable for short runs.
module display_timings_multi #(
    parameter int COORD_W      = 16,
    parameter int FRAME_CNT_W  = 16,
    parameter int DEFAULT_MODE = 2,
    parameter int H_RES_0      = 640,
    parameter int V_RES_0      = 480,
    parameter int H_RES_1      = 800,
    parameter int V_RES_1      = 600,
    parameter int H_RES_2      = 1280,
    parameter int V_RES_2      = 720,
    parameter int H_RES_3      = 1920,
    parameter int V_RES_3      = 1080
) (
    input  logic                          i_pix_clk,
    input  logic                          i_rst,
    input  logic [1:0]                    i_mode,
    output logic                          o_hs,
    output logic                          o_vs,
    output logic                          o_de,
    output logic                          o_frame,
    output logic                          o_line,
    output logic signed [COORD_W-1:0]     o_sx,
    output logic signed [COORD_W-1:0]     o_sy,
    output logic [1:0]                    o_mode_cur,
    output logic                          o_mode_chg,
    output logic [FRAME_CNT_W-1:0]        o_frame_cnt
);

    localparam logic [1:0] RST_MODE = 2'(DEFAULT_MODE);

    typedef struct packed {
        logic [COORD_W-1:0] h_sta;
        logic [COORD_W-1:0] h_end;
        logic [COORD_W-1:0] hs_beg;
        logic [COORD_W-1:0] hs_end;
        logic [COORD_W-1:0] v_sta;
        logic [COORD_W-1:0] v_end;
        logic [COORD_W-1:0] vs_beg;
        logic [COORD_W-1:0] vs_end;
        logic               h_pol;
        logic               v_pol;
    } timing_t;

    // Sync windows are half-open: [beg, end), with end = -back_porch.
    function automatic timing_t mode_timing(input logic [1:0] m);
        timing_t t;
        int      h_fp, h_sync, h_bp, h_res;
        int      v_fp, v_sync, v_bp, v_res;
        logic    pol_h, pol_v;
        h_fp  = 16;  h_sync = 96;  h_bp = 48;  h_res = H_RES_0;
        v_fp  = 10;  v_sync = 2;   v_bp = 33;  v_res = V_RES_0;
        pol_h = 1'b0; pol_v = 1'b0;
        case (m)
            2'd1: begin
                h_fp  = 40;  h_sync = 128; h_bp = 88;  h_res = H_RES_1;
                v_fp  = 1;   v_sync = 4;   v_bp = 23;  v_res = V_RES_1;
                pol_h = 1'b1; pol_v = 1'b1;
            end
            2'd2: begin
                h_fp  = 110; h_sync = 40;  h_bp = 220; h_res = H_RES_2;
                v_fp  = 5;   v_sync = 5;   v_bp = 20;  v_res = V_RES_2;
                pol_h = 1'b1; pol_v = 1'b1;
            end
            2'd3: begin
                h_fp  = 88;  h_sync = 44;  h_bp = 148; h_res = H_RES_3;
                v_fp  = 4;   v_sync = 5;   v_bp = 36;  v_res = V_RES_3;
                pol_h = 1'b1; pol_v = 1'b1;
            end
            default: begin
            end
        endcase
        t.h_sta  = COORD_W'(-(h_fp + h_sync + h_bp));
        t.h_end  = COORD_W'(h_res - 1);
        t.hs_beg = COORD_W'(-(h_sync + h_bp));
        t.hs_end = COORD_W'(-h_bp);
        t.v_sta  = COORD_W'(-(v_fp + v_sync + v_bp));
        t.v_end  = COORD_W'(v_res - 1);
        t.vs_beg = COORD_W'(-(v_sync + v_bp));
        t.vs_end = COORD_W'(-v_bp);
        t.h_pol  = pol_h;
        t.v_pol  = pol_v;
        return t;
    endfunction

    function automatic logic [COORD_W-1:0] h_sta_of(input logic [1:0] m);
        timing_t t;
        t = mode_timing(m);
        return t.h_sta;
    endfunction

    function automatic logic [COORD_W-1:0] v_sta_of(input logic [1:0] m);
        timing_t t;
        t = mode_timing(m);
        return t.v_sta;
    endfunction

    timing_t                   cur_t;
    logic signed [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [1:0]                mode_q, mode_d;
    logic [FRAME_CNT_W-1:0]    cnt_q, cnt_d;
    logic                      chg_q, chg_d;
    logic                      h_last, f_wrap, hs_act, vs_act;

    assign cur_t  = mode_timing(mode_q);
    assign h_last = (sx_q == $signed(cur_t.h_end));
    assign f_wrap = h_last && (sy_q == $signed(cur_t.v_end));
    assign hs_act = (sx_q >= $signed(cur_t.hs_beg)) && (sx_q < $signed(cur_t.hs_end));
    assign vs_act = (sy_q >= $signed(cur_t.vs_beg)) && (sy_q < $signed(cur_t.vs_end));

    always_comb begin
        sx_d   = sx_q + 1'b1;
        sy_d   = sy_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        chg_d  = 1'b0;
        if (h_last) begin
            sx_d = $signed(cur_t.h_sta);
            sy_d = sy_q + 1'b1;
            if (f_wrap) begin
                sy_d = $signed(cur_t.v_sta);
                // Request is only looked at here, so mid-frame glitches on i_mode are harmless.
                if (i_mode != mode_q) begin
                    sx_d   = $signed(h_sta_of(i_mode));
                    sy_d   = $signed(v_sta_of(i_mode));
                    mode_d = i_mode;
                    cnt_d  = '0;
                    chg_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            sx_q   <= $signed(h_sta_of(RST_MODE));
            sy_q   <= $signed(v_sta_of(RST_MODE));
            mode_q <= RST_MODE;
            cnt_q  <= '0;
            chg_q  <= 1'b0;
        end else begin
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            chg_q  <= chg_d;
        end
    end

    // Strobes decode straight from the counters and are masked while reset is held.
    assign o_hs        = (hs_act && !i_rst) ? cur_t.h_pol : ~cur_t.h_pol;
    assign o_vs        = (vs_act && !i_rst) ? cur_t.v_pol : ~cur_t.v_pol;
    assign o_de        = !i_rst && !sx_q[COORD_W-1] && !sy_q[COORD_W-1];
    assign o_line      = !i_rst && (sx_q == $signed(cur_t.h_sta));
    assign o_frame     = o_line && (sy_q == $signed(cur_t.v_sta));
    assign o_mode_chg  = chg_q && !i_rst;
    assign o_sx        = sx_q;
    assign o_sy        = sy_q;
    assign o_mode_cur  = mode_q;
    assign o_frame_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_display_timings_multi.sv
`default_nettype none
// tb_display_timings_multi: directed checks of reset, per-mode timing, frame-boundary mode switching,
// frame counter wrap and mid-frame reset, using reduced active sizes to keep frames short.
module tb_display_timings_multi;

    localparam int HR = 8;
    localparam int VR = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mode;
    logic              hs, vs, de, frame, line, mode_chg;
    logic signed [15:0] sx, sy;
    logic [1:0]        mode_cur;
    logic [1:0]        frame_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    display_timings_multi #(
        .COORD_W      (16),
        .FRAME_CNT_W  (2),
        .DEFAULT_MODE (2),
        .H_RES_0 (HR), .V_RES_0 (VR),
        .H_RES_1 (HR), .V_RES_1 (VR),
        .H_RES_2 (HR), .V_RES_2 (VR),
        .H_RES_3 (HR), .V_RES_3 (VR)
    ) dut (
        .i_pix_clk   (clk),
        .i_rst       (rst),
        .i_mode      (mode),
        .o_hs        (hs),
        .o_vs        (vs),
        .o_de        (de),
        .o_frame     (frame),
        .o_line      (line),
        .o_sx        (sx),
        .o_sy        (sy),
        .o_mode_cur  (mode_cur),
        .o_mode_chg  (mode_chg),
        .o_frame_cnt (frame_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Runs from a frame-start sample to the next one, optionally changing the mode request mid-frame.
    task automatic run_frame(input string tag, input int e_clks, input int e_hper, input int e_lines,
                             input int e_hs_lo, input int e_hs_hi, input int e_vs_lo, input int e_vs_hi,
                             input logic hpol, input logic vpol, input int e_hs_len,
                             input int at1, input logic [1:0] m1, input int at2, input logic [1:0] m2);
        int clks = 0, de_n = 0, lines = 0, hs_n = 0, per_bad = 0, last = 0;
        int hs_lo = 32767, hs_hi = -32768, vs_lo = 32767, vs_hi = -32768;
        do begin
            if (clks == at1) mode = m1;
            if (clks == at2) mode = m2;
            if (de) de_n++;
            if (hs == hpol) begin
                hs_n++;
                if (sx < hs_lo) hs_lo = sx;
                if (sx > hs_hi) hs_hi = sx;
            end
            if (vs == vpol) begin
                if (sy < vs_lo) vs_lo = sy;
                if (sy > vs_hi) vs_hi = sy;
            end
            if (line) begin
                lines++;
                if (lines > 1 && (clks - last) != e_hper) per_bad++;
                last = clks;
            end
            tick;
            clks++;
        end while (!frame && clks < 20000);
        chk({tag, "_frame_clks"}, clks, e_clks);
        chk({tag, "_lines"}, lines, e_lines);
        chk({tag, "_line_period_errs"}, per_bad, 0);
        chk({tag, "_de_clks"}, de_n, HR * VR);
        chk({tag, "_hs_first_sx"}, hs_lo, e_hs_lo);
        chk({tag, "_hs_last_sx"}, hs_hi, e_hs_hi);
        chk({tag, "_hs_clks"}, hs_n, e_hs_len * e_lines);
        chk({tag, "_vs_first_sy"}, vs_lo, e_vs_lo);
        chk({tag, "_vs_last_sy"}, vs_hi, e_vs_hi);
    endtask

    initial begin
        rst  = 1'b1;
        mode = 2'd2;
        repeat (3) tick;

        chk("rst_sx", sx, -370);
        chk("rst_sy", sy, -30);
        chk("rst_hs", hs, 0);
        chk("rst_vs", vs, 0);
        chk("rst_de", de, 0);
        chk("rst_frame", frame, 0);
        chk("rst_line", line, 0);
        chk("rst_chg", mode_chg, 0);
        chk("rst_mode", mode_cur, 2);
        chk("rst_cnt", frame_cnt, 0);

        rst = 1'b0;
        #1;
        chk("rel_frame", frame, 1);
        chk("rel_line", line, 1);
        chk("rel_chg", mode_chg, 0);

        // Mode 2 frame; request mode 0 mid-frame, timing must stay mode 2 until the wrap.
        run_frame("m2", 12096, 378, 32, -260, -221, -25, -21, 1'b1, 1'b1, 40, 5000, 2'd0, -1, 2'd0);
        chk("sw0_chg", mode_chg, 1);
        chk("sw0_frame", frame, 1);
        chk("sw0_mode", mode_cur, 0);
        chk("sw0_sx", sx, -160);
        chk("sw0_sy", sy, -45);
        chk("sw0_cnt", frame_cnt, 0);
        chk("sw0_hs_idle", hs, 1);
        chk("sw0_vs_idle", vs, 1);

        // Request bounces 0->3->0 inside the frame: no switch, count advances.
        run_frame("m0_tog", 7896, 168, 47, -144, -49, -35, -34, 1'b0, 1'b0, 96, 2000, 2'd3, 3000, 2'd0);
        chk("tog_chg", mode_chg, 0);
        chk("tog_frame", frame, 1);
        chk("tog_mode", mode_cur, 0);
        chk("tog_cnt", frame_cnt, 1);

        // Two-bit frame counter: 1 -> 2 -> 3 -> 0.
        for (int k = 0; k < 3; k++) begin
            run_frame("m0_run", 7896, 168, 47, -144, -49, -35, -34, 1'b0, 1'b0, 96, -1, 2'd0, -1, 2'd0);
            chk("run_cnt", frame_cnt, (k + 2) % 4);
            chk("run_chg", mode_chg, 0);
        end

        run_frame("m0_req3", 7896, 168, 47, -144, -49, -35, -34, 1'b0, 1'b0, 96, 100, 2'd3, -1, 2'd3);
        chk("sw3_chg", mode_chg, 1);
        chk("sw3_mode", mode_cur, 3);
        chk("sw3_sx", sx, -280);
        chk("sw3_sy", sy, -45);
        chk("sw3_cnt", frame_cnt, 0);

        run_frame("m3", 13536, 288, 47, -192, -149, -41, -37, 1'b1, 1'b1, 44, 100, 2'd1, -1, 2'd1);
        chk("sw1_chg", mode_chg, 1);
        chk("sw1_mode", mode_cur, 1);
        chk("sw1_sx", sx, -256);
        chk("sw1_sy", sy, -28);
        chk("sw1_cnt", frame_cnt, 0);

        // Mode 1 with a pending switch to 0, then reset mid-frame inside the active area.
        mode = 2'd0;
        for (int i = 0; i < 10000 && !(sx == 16'sd3 && sy == 16'sd0); i++) tick;
        chk("m1_reach_pos", int'(sx == 16'sd3 && sy == 16'sd0), 1);
        chk("m1_de", de, 1);
        chk("m1_mode", mode_cur, 1);

        rst = 1'b1;
        #1;
        chk("abort_de", de, 0);
        chk("abort_chg", mode_chg, 0);
        tick;
        chk("abort_mode", mode_cur, 2);
        chk("abort_sx", sx, -370);
        chk("abort_sy", sy, -30);
        chk("abort_cnt", frame_cnt, 0);
        chk("abort_frame", frame, 0);

        rst = 1'b0;
        #1;
        chk("rel2_frame", frame, 1);
        chk("rel2_chg", mode_chg, 0);
        repeat (5) tick;
        chk("rel2_mode", mode_cur, 2);
        chk("rel2_sx", sx, -365);
        chk("rel2_chg_late", mode_chg, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
